// File: rtl/phy_traffic_gen_chk.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : phy_traffic_gen_chk
//  Description : Multi-lane burst traffic generator with a valid-driven
//                per-lane sequence checker for PHY loopback and self-test.
//  Revision    : 1.0 - initial release
// ============================================================================
module phy_traffic_gen_chk #(
  parameter int LANES     = 4,
  parameter int WIDTH     = 8,
  parameter int BURST_LEN = 14,
  parameter int SEED0     = 8'hEE,
  parameter int SEED_STEP = 8'h11,
  parameter int TIMEOUT   = 64
) (
  input  logic                   clk_f,
  input  logic                   reset,
  input  logic                   start,
  input  logic [1:0]             mode,
  output logic [LANES*WIDTH-1:0] data_out,
  output logic [LANES-1:0]       valid_out,
  input  logic [LANES*WIDTH-1:0] data_rx,
  input  logic [LANES-1:0]       valid_rx,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [LANES-1:0]       err_lane,
  output logic [15:0]            err_count,
  output logic                   timeout
);

  localparam int                c_to_w    = $clog2(TIMEOUT + 1);
  localparam int                c_inc_w   = $clog2(LANES + 1);
  localparam logic [7:0]        c_burst   = 8'(BURST_LEN);
  localparam logic [c_to_w-1:0] c_to_last = c_to_w'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t                 r_state, w_state_nxt;
  logic [LANES*WIDTH-1:0] w_seed_vec, w_tx_data, r_data;
  logic [LANES-1:0]       r_valid, r_err_lane, w_lane_err;
  logic [7:0]             r_tx_beat;
  logic                   r_phase, r_mode_alt;
  logic [c_to_w-1:0]      r_drain_cnt;
  logic [WIDTH-1:0]       r_exp [LANES];
  logic [7:0]             r_rx_cnt [LANES];
  logic [15:0]            r_err_count;
  logic                   r_timeout;
  logic                   w_start_ok, w_run_last, w_emit, w_active, w_all_rx, w_drain_exp;
  logic [c_inc_w-1:0]     w_err_inc;
  logic [16:0]            w_err_sum;

  // Per-lane seed, next TX word and error detection (overrun or data mismatch)
  genvar g;
  generate
    for (g = 0; g < LANES; g++) begin : g_lane
      localparam logic [WIDTH-1:0] c_seed = WIDTH'(SEED0 + g * SEED_STEP);
      assign w_seed_vec[g*WIDTH +: WIDTH] = c_seed;
      assign w_tx_data[g*WIDTH +: WIDTH]  = c_seed + WIDTH'(r_tx_beat);
      assign w_lane_err[g] = w_active && valid_rx[g] &&
                             ((r_rx_cnt[g] == c_burst) ||
                              (data_rx[g*WIDTH +: WIDTH] != r_exp[g]));
    end
  endgenerate

  // Restart is only honoured outside an active burst
  assign w_start_ok  = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // r_tx_beat counts beats already emitted, so reaching BURST_LEN ends RUN
  assign w_run_last  = (r_state == S_RUN) && (r_tx_beat == c_burst);
  assign w_emit      = (r_state == S_RUN) && !w_run_last && (!r_mode_alt || !r_phase);
  assign w_active    = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign w_drain_exp = (r_drain_cnt == c_to_last);
  assign w_err_sum   = {1'b0, r_err_count} + 17'(w_err_inc);

  // All lanes have received a full burst
  always_comb begin
    w_all_rx = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      if (r_rx_cnt[i] != c_burst) w_all_rx = 1'b0;
    end
  end

  // Number of lanes flagging an error this cycle
  always_comb begin
    w_err_inc = '0;
    for (int i = 0; i < LANES; i++) begin
      w_err_inc = w_err_inc + c_inc_w'(w_lane_err[i]);
    end
  end

  // State register
  always_ff @(posedge clk_f) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic; completion is tested before timeout so it wins a tie
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_run_last) w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_all_rx || w_drain_exp) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Generator, checker and status datapath
  always_ff @(posedge clk_f) begin
    if (reset) begin
      r_data      <= '0;
      r_valid     <= '0;
      r_tx_beat   <= '0;
      r_phase     <= 1'b0;
      r_mode_alt  <= 1'b0;
      r_drain_cnt <= '0;
      r_err_lane  <= '0;
      r_err_count <= '0;
      r_timeout   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_exp[i]    <= '0;
        r_rx_cnt[i] <= '0;
      end
    end else if (w_start_ok) begin
      // Beat 0 goes out immediately so it is visible in the first RUN cycle
      r_mode_alt  <= (mode == 2'd1);
      r_data      <= w_seed_vec;
      r_valid     <= '1;
      r_tx_beat   <= 8'd1;
      r_phase     <= 1'b1;
      r_drain_cnt <= '0;
      r_err_lane  <= '0;
      r_err_count <= '0;
      r_timeout   <= 1'b0;
      for (int i = 0; i < LANES; i++) begin
        r_exp[i]    <= w_seed_vec[i*WIDTH +: WIDTH];
        r_rx_cnt[i] <= '0;
      end
    end else begin
      r_valid <= '0;
      if (w_emit) begin
        r_valid   <= '1;
        r_data    <= w_tx_data;
        r_tx_beat <= r_tx_beat + 8'd1;
      end
      if (r_state == S_RUN) r_phase <= ~r_phase;
      if (r_state == S_DRAIN) begin
        r_drain_cnt <= r_drain_cnt + 1'b1;
        if (!w_all_rx && w_drain_exp) r_timeout <= 1'b1;
      end
      // Expected value advances on every in-range beat; no resync after errors
      for (int i = 0; i < LANES; i++) begin
        if (w_active && valid_rx[i] && (r_rx_cnt[i] != c_burst)) begin
          r_exp[i]    <= r_exp[i] + 1'b1;
          r_rx_cnt[i] <= r_rx_cnt[i] + 8'd1;
        end
      end
      r_err_lane <= r_err_lane | w_lane_err;
      if (|w_lane_err) r_err_count <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign busy      = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign done      = (r_state == S_DONE);
  assign pass      = done && (r_err_lane == '0) && !r_timeout;
  assign err_lane  = r_err_lane;
  assign err_count = r_err_count;
  assign timeout   = r_timeout;

endmodule
`default_nettype wire

// File: tb/tb_phy_traffic_gen_chk.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_phy_traffic_gen_chk
//  Description : Directed loopback bench with TX scoreboard for
//                phy_traffic_gen_chk (default seeds and a wrapping-seed copy).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_phy_traffic_gen_chk;

  localparam int BL = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        start_a = 1'b0, start_w = 1'b0;
  logic [1:0]  mode_a = 2'd0, mode_w = 2'd0;
  logic [31:0] data_out_a, data_rx_a, data_out_w;
  logic [3:0]  valid_out_a, valid_rx_a, valid_out_w;
  logic        busy_a, done_a, pass_a, timeout_a;
  logic        busy_w, done_w, pass_w, timeout_w;
  logic [3:0]  err_lane_a, err_lane_w;
  logic [15:0] err_count_a, err_count_w;

  phy_traffic_gen_chk dut_a (
    .clk_f(clk), .reset(rst), .start(start_a), .mode(mode_a),
    .data_out(data_out_a), .valid_out(valid_out_a),
    .data_rx(data_rx_a), .valid_rx(valid_rx_a),
    .busy(busy_a), .done(done_a), .pass(pass_a),
    .err_lane(err_lane_a), .err_count(err_count_a), .timeout(timeout_a)
  );

  phy_traffic_gen_chk #(.SEED0(8'hF8)) dut_w (
    .clk_f(clk), .reset(rst), .start(start_w), .mode(mode_w),
    .data_out(data_out_w), .valid_out(valid_out_w),
    .data_rx(data_out_w), .valid_rx(valid_out_w),
    .busy(busy_w), .done(done_w), .pass(pass_w),
    .err_lane(err_lane_w), .err_count(err_count_w), .timeout(timeout_w)
  );

  int errors = 0, checks = 0, cyc = 0;
  logic [31:0] q_a[$], q_w[$];
  int beats_a = 0, first_a = 0, last_a = 0;
  int beats_w = 0, first_w = 0, last_w = 0;
  logic corrupt_en = 1'b0, drop_en = 1'b0, extra_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_true(input string tag, input logic cond);
    checks++;
    assert (cond === 1'b1) else begin
      errors++;
      $error("FAIL %s: observed=0 expected=1", tag);
    end
  endtask

  function automatic logic [31:0] beat_vec(input logic [7:0] s0, input int b);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[i*8 +: 8] = 8'(int'(s0) + i * 17 + b);
    return v;
  endfunction

  // 3-cycle loopback for dut_a with fault-injection hooks
  logic [31:0] r_dly_d [3];
  logic [3:0]  r_dly_v [3];
  int          rx_beat = 0;
  logic        extra_used = 1'b0;
  logic        w_extra;

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        r_dly_d[i] <= '0;
        r_dly_v[i] <= '0;
      end
    end else begin
      r_dly_d[0] <= data_out_a;  r_dly_v[0] <= valid_out_a;
      r_dly_d[1] <= r_dly_d[0];  r_dly_v[1] <= r_dly_v[0];
      r_dly_d[2] <= r_dly_d[1];  r_dly_v[2] <= r_dly_v[1];
    end
    if (start_a) begin
      rx_beat    <= 0;
      extra_used <= 1'b0;
    end else begin
      if (r_dly_v[2][0]) rx_beat <= rx_beat + 1;
      if (w_extra) extra_used <= 1'b1;
    end
  end

  always_comb begin
    data_rx_a  = r_dly_d[2];
    valid_rx_a = r_dly_v[2];
    w_extra    = 1'b0;
    if (corrupt_en && r_dly_v[2][2] && rx_beat == 5)
      data_rx_a[16 +: 8] = r_dly_d[2][16 +: 8] ^ 8'h01;
    if (drop_en && rx_beat >= 12) valid_rx_a[1] = 1'b0;
    if (extra_en && !extra_used && rx_beat == BL && r_dly_v[2] == 4'h0) begin
      valid_rx_a = 4'hF;
      w_extra    = 1'b1;
    end
  end

  // TX scoreboard: every valid beat pops its expected lane vector
  always @(negedge clk) begin
    if (!rst && valid_out_a !== 4'h0) begin
      check("a_valid_all_lanes", valid_out_a, 4'hF);
      check_true("a_beat_expected", q_a.size() != 0);
      if (q_a.size() != 0) check("a_tx_data", data_out_a, q_a.pop_front());
      if (beats_a == 0) first_a = cyc;
      last_a = cyc;
      beats_a++;
    end
    if (!rst && valid_out_w !== 4'h0) begin
      check("w_valid_all_lanes", valid_out_w, 4'hF);
      check_true("w_beat_expected", q_w.size() != 0);
      if (q_w.size() != 0) check("w_tx_data", data_out_w, q_w.pop_front());
      if (beats_w == 0) first_w = cyc;
      else check("w_alt_gap", cyc - last_w, 2);
      last_w = cyc;
      beats_w++;
    end
  end

  task automatic start_a_burst(input logic [1:0] m);
    for (int b = 0; b < BL; b++) q_a.push_back(beat_vec(8'hEE, b));
    beats_a = 0;
    @(negedge clk);
    start_a = 1'b1;
    mode_a  = m;
    @(negedge clk);
    start_a = 1'b0;
    mode_a  = (m == 2'd1) ? 2'd0 : 2'd1;
    check("a_first_beat_latency", valid_out_a, 4'hF);
    check("a_busy_in_run", busy_a, 1'b1);
  endtask

  task automatic wait_done_a(output int dcyc);
    int n = 0;
    while (done_a !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_true("a_done_reached", done_a);
    dcyc = cyc;
  endtask

  int dc, n;

  initial begin
    // Reset for two cycles
    repeat (2) @(negedge clk);
    check("rst_valid_out", valid_out_a, 4'h0);
    check("rst_data_out", data_out_a, 32'h0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_pass", pass_a, 1'b0);
    check("rst_err_lane", err_lane_a, 4'h0);
    check("rst_err_count", err_count_a, 16'h0);
    check("rst_timeout", timeout_a, 1'b0);
    rst = 1'b0;

    // Continuous loopback
    start_a_burst(2'd0);
    wait_done_a(dc);
    check("t1_pass", pass_a, 1'b1);
    check("t1_err_count", err_count_a, 16'h0);
    check("t1_err_lane", err_lane_a, 4'h0);
    check("t1_timeout", timeout_a, 1'b0);
    check("t1_busy_in_done", busy_a, 1'b0);
    check("t1_beats", beats_a, BL);
    check("t1_back_to_back_span", last_a - first_a, BL - 1);
    check("t1_done_after_last_tx", dc - last_a, 5);
    check("t1_data_holds", data_out_a, beat_vec(8'hEE, BL - 1));
    check("t1_sb_empty", q_a.size(), 0);

    // Wrapping seed, alternate-cycle valid
    for (int b = 0; b < BL; b++) q_w.push_back(beat_vec(8'hF8, b));
    @(negedge clk);
    start_w = 1'b1;
    mode_w  = 2'd1;
    @(negedge clk);
    start_w = 1'b0;
    mode_w  = 2'd0;
    n = 0;
    while (done_w !== 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    check_true("t2_done_reached", done_w);
    check("t2_pass", pass_w, 1'b1);
    check("t2_err", {err_lane_w, err_count_w, timeout_w, busy_w}, 22'h0);
    check("t2_beats", beats_w, BL);
    check("t2_run_span", last_w - first_w, 2 * BL - 2);
    check("t2_lane0_last", data_out_w[7:0], 8'h05);
    check("t2_sb_empty", q_w.size(), 0);

    // Corrupt lane 2 beat 5 (restart from DONE)
    corrupt_en = 1'b1;
    start_a_burst(2'd0);
    wait_done_a(dc);
    corrupt_en = 1'b0;
    check("t3_err_lane", err_lane_a, 4'b0100);
    check("t3_err_count", err_count_a, 16'd1);
    check("t3_pass", pass_a, 1'b0);
    check("t3_timeout", timeout_a, 1'b0);

    // Drop the last two beats of lane 1
    drop_en = 1'b1;
    start_a_burst(2'd0);
    wait_done_a(dc);
    drop_en = 1'b0;
    check("t4_timeout", timeout_a, 1'b1);
    check("t4_pass", pass_a, 1'b0);
    check("t4_err_count", err_count_a, 16'h0);
    check("t4_err_lane", err_lane_a, 4'h0);
    check("t4_drain_len", dc - last_a, 65);

    // Overrun on all lanes in DRAIN
    extra_en = 1'b1;
    start_a_burst(2'd0);
    wait_done_a(dc);
    check("t5_err_lane", err_lane_a, 4'hF);
    check("t5_err_count", err_count_a, 16'd4);
    check("t5_pass", pass_a, 1'b0);
    check("t5_timeout", timeout_a, 1'b0);

    // Saturation: preload near the top, then four simultaneous errors
    start_a_burst(2'd0);
    repeat (2) @(negedge clk);
    force dut_a.r_err_count = 16'hFFFE;
    @(negedge clk);
    release dut_a.r_err_count;
    @(negedge clk);
    check("t5_preload_held", err_count_a, 16'hFFFE);
    wait_done_a(dc);
    extra_en = 1'b0;
    check("t5_saturated", err_count_a, 16'hFFFF);
    check("t5_sat_err_lane", err_lane_a, 4'hF);

    // Reset mid-RUN at beat 7
    start_a_burst(2'd0);
    n = 0;
    while (beats_a < 7 && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("t6_reached_beat7", beats_a, 7);
    rst = 1'b1;
    @(negedge clk);
    check("t6_valid_out", valid_out_a, 4'h0);
    check("t6_data_out", data_out_a, 32'h0);
    check("t6_busy", busy_a, 1'b0);
    check("t6_flags", {done_a, pass_a, timeout_a, err_lane_a, err_count_a}, 23'h0);
    rst = 1'b0;
    q_a.delete();
    repeat (6) @(negedge clk);
    check("t6_idle_no_tx", beats_a, 7);

    // Replay from seed in reserved mode 2; a start pulse mid-RUN is ignored
    start_a_burst(2'd2);
    repeat (3) @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    wait_done_a(dc);
    check("t6_pass", pass_a, 1'b1);
    check("t6_err_count", err_count_a, 16'h0);
    check("t6_beats", beats_a, BL);
    check("t6_span", last_a - first_a, BL - 1);
    check("t6_done_after_last_tx", dc - last_a, 5);
    check("t6_sb_empty", q_a.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/phy_traffic_gen_chk.md
Name: phy_traffic_gen_chk

Overview:
Synthesizable, parametrised multi-lane traffic generator and self-checker for the PHY datapath.
- Generator drives LANES byte lanes with per-lane incrementing patterns in bursts. Valid gating is selected at run time.
- Checker compares the PHY receive lanes against the expected sequences and counts errors.
- Sits around the PHY in loopback benches and on-board self-test. Replaces hand-sequenced stimulus.

Parameters:
- LANES, 4, number of parallel lanes.
- WIDTH, 8, bits per lane.
- BURST_LEN, 14, beats per lane per burst (>=1, <=255).
- SEED0, 8'hEE, start value of lane 0.
- SEED_STEP, 8'h11, seed increment between lanes; lane i seed = SEED0 + i*SEED_STEP mod 2^WIDTH.
- TIMEOUT, 64, maximum cycles spent in DRAIN.

Ports:
- clk_f, in, 1, single clock; everything is posedge.
- reset, in, 1, synchronous, active-high.
- start, in, 1, one-cycle pulse that launches a burst.
- mode, in, 2, valid gating: 0 continuous, 1 alternate cycles, 2 and 3 reserved (treated as 0); sampled on the start cycle.
- data_out, out, LANES*WIDTH, TX lanes; lane i occupies bits [i*WIDTH +: WIDTH].
- valid_out, out, LANES, per-lane TX valid.
- data_rx, in, LANES*WIDTH, RX lanes from the PHY.
- valid_rx, in, LANES, per-lane RX valid.
- busy, out, 1, high in RUN or DRAIN.
- done, out, 1, high in DONE.
- pass, out, 1, done & (err_lane==0) & !timeout.
- err_lane, out, LANES, sticky per-lane mismatch or overrun flag.
- err_count, out, 16, total error beats; saturates at 16'hFFFF.
- timeout, out, 1, sticky; DRAIN expired.

Behaviour:
- Reset (reset=1 at a clk_f edge, from any state, including mid-burst):
  - State goes to IDLE next cycle.
  - All outputs 0; data_out = 0.
  - All counters and flags cleared.
- FSM states: IDLE, RUN, DRAIN, DONE.
- IDLE:
  - start=1 -> RUN. Latch mode. Load tx_beat=0 and phase=0.
  - Load each lane's exp_i = seed_i and rx_cnt_i = 0.
  - Clear err_lane, err_count and timeout.
- RUN:
  - Emit cycle: mode 0 every cycle; mode 1 only when phase=0 (phase toggles each RUN cycle, first RUN cycle emits).
  - On an emit cycle: valid_out = all ones; lane i data = seed_i + tx_beat (mod 2^WIDTH, wraps silently); tx_beat increments.
  - On a non-emit cycle: valid_out = 0 and data_out holds its last value.
  - Registered outputs: first valid beat appears the cycle after start is sampled.
  - After the beat with tx_beat = BURST_LEN-1 -> DRAIN.
- DRAIN:
  - valid_out = 0; the cycle counter runs.
  - All rx_cnt_i == BURST_LEN -> DONE.
  - Else counter reaches TIMEOUT -> DONE with timeout=1.
  - If both happen on the same cycle, completion wins and timeout stays 0.
- DONE:
  - done=1; flags and counts hold.
  - start=1 -> RUN (re-initialised as from IDLE).
- start in RUN or DRAIN is ignored.
- Checker (active only in RUN and DRAIN; valid_rx ignored in IDLE and DONE), per lane i on valid_rx[i]=1:
  - If rx_cnt_i < BURST_LEN: compare lane i of data_rx with exp_i. On mismatch set err_lane[i] and add 1 error.
  - Then exp_i++ (mod 2^WIDTH; no resync on error) and rx_cnt_i++.
  - If rx_cnt_i == BURST_LEN: overrun; set err_lane[i] and add 1 error; rx_cnt_i holds.
- Error counting:
  - err_count adds the number of lanes erroring in that cycle (0..LANES) and saturates, never wraps.
  - Error flags and counts update the cycle after the offending beat.
- Latency between TX and RX is arbitrary; the checker is purely valid-driven.
- Lanes may arrive skewed relative to each other.

Test Plan:
- Continuous loopback: reset 2 cycles, start, mode=0, data_rx/valid_rx = data_out/valid_out delayed 3 cycles -> lane0 emits EE..FB and lane3 emits 21..2E; 14 valid cycles back-to-back; DONE; pass=1; err_count=0.
- Wrap and alternate: SEED0=8'hF8, mode=1 -> lane0 emits F8..FF then 00..05 on alternate cycles; RUN lasts 27 cycles; pass=1.
- Corruption: XOR lane 2 beat 5 with 8'h01 in the loopback -> err_lane=4'b0100, err_count=1, pass=0, timeout=0.
- Missing beats: drop the last 2 beats of lane 1 -> DRAIN expires after 64 cycles; timeout=1; pass=0; err_count=0.
- Overrun and simultaneous errors: inject one extra valid beat on all 4 lanes in DRAIN -> err_lane=4'hF, err_count=4. Saturation check: force err_count=16'hFFFE, then 4 errors -> 16'hFFFF.
- Reset mid-RUN at beat 7 -> next cycle IDLE, valid_out=0, busy=0, flags 0. A new start replays from seed with pass=1. start pulsed during RUN has no effect.
